mem_controller: RTL and testbench

MEM_CONTROLLER -- requirements
Module: mem_controller

---
 rtl/mem_ctrl_pkg.sv | 6 +
 rtl/mem_controller.sv | 65 ++++++
 tb/tb_mem_controller.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared FSM state encoding and default widths for mem_controller
package mem_ctrl_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {IDLE, WRITE, READ_REQ, READ_WAIT} state_t;
endpackage

// File: rtl/mem_controller.sv
// mem_controller: single-outstanding CPU-to-DDR bridge, one-cycle DDR strobes, registered outputs
module mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_wr_req,
  input  logic                  cpu_rd_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data_in,
  output logic [DATA_WIDTH-1:0] cpu_data_out,
  output logic                  cpu_data_valid,
  output logic                  ddr_wr_req,
  output logic                  ddr_rd_req,
  output logic [ADDR_WIDTH-1:0] ddr_addr,
  output logic [DATA_WIDTH-1:0] ddr_wr_data,
  input  logic [DATA_WIDTH-1:0] ddr_rd_data,
  input  logic                  ddr_rd_valid
);
  state_t state, state_n;
  logic                  idle, capture, wr_n, rd_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdata_n, dout_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state          <= IDLE;
      cpu_data_out   <= '0;
      cpu_data_valid <= 1'b0;
      ddr_wr_req     <= 1'b0;
      ddr_rd_req     <= 1'b0;
      ddr_addr       <= '0;
      ddr_wr_data    <= '0;
    end else begin
      state          <= state_n;
      cpu_data_out   <= dout_n;
      cpu_data_valid <= capture;
      ddr_wr_req     <= wr_n;
      ddr_rd_req     <= rd_n;
      ddr_addr       <= addr_n;
      ddr_wr_data    <= wdata_n;
    end
  // write wins over a simultaneous read; requests outside IDLE are dropped
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = cpu_wr_req ? WRITE : cpu_rd_req ? READ_REQ : IDLE;
      WRITE:     state_n = IDLE;
      READ_REQ:  state_n = READ_WAIT;
      READ_WAIT: state_n = ddr_rd_valid ? IDLE : READ_WAIT;
      default:   state_n = IDLE;
    endcase
  end
  always_comb begin
    idle    = state == IDLE;
    capture = state == READ_WAIT && ddr_rd_valid;
    wr_n    = idle && cpu_wr_req;
    rd_n    = idle && cpu_rd_req && !cpu_wr_req;
    addr_n  = (wr_n || rd_n) ? cpu_addr : ddr_addr;
    wdata_n = wr_n ? cpu_data_in : ddr_wr_data;
    dout_n  = capture ? ddr_rd_data : cpu_data_out;
  end
endmodule

// File: tb/tb_mem_controller.sv
// tb_mem_controller: directed vector table plus reset-abort sequence; bench plays a 1-cycle DDR
module tb_mem_controller;
  logic        clk = 1'b0, reset = 1'b1;
  logic        cpu_wr_req = 1'b0, cpu_rd_req = 1'b0, ddr_rd_valid = 1'b0;
  logic [9:0]  cpu_addr = '0;
  logic [31:0] cpu_data_in = '0, ddr_rd_data = '0;
  logic [31:0] cpu_data_out, ddr_wr_data;
  logic        cpu_data_valid, ddr_wr_req, ddr_rd_req;
  logic [9:0]  ddr_addr;
  int checks = 0, fails = 0;

  mem_controller dut (
    .clk(clk), .reset(reset), .cpu_wr_req(cpu_wr_req), .cpu_rd_req(cpu_rd_req),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
    .cpu_data_valid(cpu_data_valid), .ddr_wr_req(ddr_wr_req), .ddr_rd_req(ddr_rd_req),
    .ddr_addr(ddr_addr), .ddr_wr_data(ddr_wr_data), .ddr_rd_data(ddr_rd_data),
    .ddr_rd_valid(ddr_rd_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic wr, rd; logic [9:0] addr; logic [31:0] din, rdd; logic rv;
    logic e_wr, e_rd; logic [9:0] e_addr; logic [31:0] e_wdata; logic e_valid; logic [31:0] e_dout;
  } vec_t;
  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic wr, input logic rd, input logic [9:0] a,
                           input logic [31:0] wd, input logic v, input logic [31:0] d);
    check({tag, ".ddr_wr_req"}, 32'(ddr_wr_req), 32'(wr));
    check({tag, ".ddr_rd_req"}, 32'(ddr_rd_req), 32'(rd));
    check({tag, ".ddr_addr"}, 32'(ddr_addr), 32'(a));
    check({tag, ".ddr_wr_data"}, ddr_wr_data, wd);
    check({tag, ".cpu_data_valid"}, 32'(cpu_data_valid), 32'(v));
    check({tag, ".cpu_data_out"}, cpu_data_out, d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 10'd5,  32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 1'b0, 10'd5,  32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 10'd0,  32'h0, 32'h0, 1'b0,        1'b0, 1'b0, 10'd5,  32'hDEADBEEF, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 10'd5,  32'h0, 32'h0, 1'b0,        1'b0, 1'b1, 10'd5,  32'hDEADBEEF, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 10'd0,  32'h0, 32'h0, 1'b0,        1'b0, 1'b0, 10'd5,  32'hDEADBEEF, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 10'd0,  32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 10'd5,  32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    vecs[5]  = '{1'b0, 1'b1, 10'd10, 32'h0, 32'h0, 1'b0,        1'b0, 1'b1, 10'd10, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    vecs[6]  = '{1'b0, 1'b0, 10'd0,  32'h0, 32'h0, 1'b0,        1'b0, 1'b0, 10'd10, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    vecs[7]  = '{1'b0, 1'b0, 10'd0,  32'h0, 32'hCAFEBABE, 1'b1, 1'b0, 1'b0, 10'd10, 32'hDEADBEEF, 1'b1, 32'hCAFEBABE};
    vecs[8]  = '{1'b1, 1'b1, 10'd3,  32'h12345678, 32'h0, 1'b0, 1'b1, 1'b0, 10'd3,  32'h12345678, 1'b0, 32'hCAFEBABE};
    vecs[9]  = '{1'b0, 1'b0, 10'd0,  32'h0, 32'h0, 1'b0,        1'b0, 1'b0, 10'd3,  32'h12345678, 1'b0, 32'hCAFEBABE};
    vecs[10] = '{1'b0, 1'b1, 10'd7,  32'h0, 32'h0, 1'b0,        1'b0, 1'b1, 10'd7,  32'h12345678, 1'b0, 32'hCAFEBABE};
    vecs[11] = '{1'b0, 1'b0, 10'd0,  32'h0, 32'h0, 1'b0,        1'b0, 1'b0, 10'd7,  32'h12345678, 1'b0, 32'hCAFEBABE};
    vecs[12] = '{1'b1, 1'b0, 10'd9,  32'h55, 32'h0, 1'b0,       1'b0, 1'b0, 10'd7,  32'h12345678, 1'b0, 32'hCAFEBABE};
    vecs[13] = '{1'b0, 1'b0, 10'd0,  32'h0, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, 10'd7,  32'h12345678, 1'b1, 32'hA5A5A5A5};
    vecs[14] = '{1'b0, 1'b0, 10'd0,  32'h0, 32'h11111111, 1'b1, 1'b0, 1'b0, 10'd7,  32'h12345678, 1'b0, 32'hA5A5A5A5};
    vecs[15] = '{1'b0, 1'b1, 10'd2,  32'h0, 32'h0, 1'b0,        1'b0, 1'b1, 10'd2,  32'h12345678, 1'b0, 32'hA5A5A5A5};
    vecs[16] = '{1'b0, 1'b0, 10'd0,  32'h0, 32'h22222222, 1'b1, 1'b0, 1'b0, 10'd2,  32'h12345678, 1'b0, 32'hA5A5A5A5};
    vecs[17] = '{1'b0, 1'b0, 10'd0,  32'h0, 32'h0, 1'b0,        1'b0, 1'b0, 10'd2,  32'h12345678, 1'b0, 32'hA5A5A5A5};
    vecs[18] = '{1'b0, 1'b0, 10'd0,  32'h0, 32'h33333333, 1'b1, 1'b0, 1'b0, 10'd2,  32'h12345678, 1'b1, 32'h33333333};
    vecs[19] = '{1'b1, 1'b0, 10'd1,  32'h44, 32'h0, 1'b0,       1'b1, 1'b0, 10'd1,  32'h44, 1'b0, 32'h33333333};
    vecs[20] = '{1'b0, 1'b0, 10'd0,  32'h0, 32'h99, 1'b1,       1'b0, 1'b0, 10'd1,  32'h44, 1'b0, 32'h33333333};

    #1;
    check_all("reset", 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      cpu_wr_req = vecs[i].wr; cpu_rd_req = vecs[i].rd; cpu_addr = vecs[i].addr;
      cpu_data_in = vecs[i].din; ddr_rd_data = vecs[i].rdd; ddr_rd_valid = vecs[i].rv;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_wr, vecs[i].e_rd, vecs[i].e_addr,
                vecs[i].e_wdata, vecs[i].e_valid, vecs[i].e_dout);
    end

    // reset while waiting for DDR data aborts the read with no valid pulse
    @(negedge clk);
    cpu_wr_req = 1'b0; cpu_rd_req = 1'b1; cpu_addr = 10'd4; ddr_rd_valid = 1'b0;
    step();
    check_all("abort.req", 1'b0, 1'b1, 10'd4, 32'h44, 1'b0, 32'h33333333);
    @(negedge clk);
    cpu_rd_req = 1'b0;
    step();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_all("abort.async", 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 32'h0);
    ddr_rd_valid = 1'b1; ddr_rd_data = 32'h77;
    step();
    check_all("abort.held", 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    reset = 1'b0; ddr_rd_valid = 1'b0; cpu_rd_req = 1'b1; cpu_addr = 10'd6;
    step();
    check_all("after.req", 1'b0, 1'b1, 10'd6, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    cpu_rd_req = 1'b0;
    step();
    @(negedge clk);
    ddr_rd_valid = 1'b1; ddr_rd_data = 32'h66;
    step();
    check_all("after.data", 1'b0, 1'b0, 10'd6, 32'h0, 1'b1, 32'h66);
    @(negedge clk);
    ddr_rd_valid = 1'b0;
    step();
    check_all("after.idle", 1'b0, 1'b0, 10'd6, 32'h0, 1'b0, 32'h66);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
